// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer/flag block.
// master: producer / testbench side (drives wr_en, read pointer, ovf_clr).
// slave : fifo_wptr_full (drives write strobe, address, Gray pointer and flags).
// Signals:
//   wr_en           write request
//   rptr_gray_async Gray read pointer from the read domain, unsynchronised
//   ovf_clr         clears the sticky overflow flag
//   wr_accept       RAM write strobe (wr_en & ~full)
//   waddr           RAM write address
//   wptr_gray       registered Gray write pointer for the read domain
//   full            registered full flag
//   almost_full     registered level >= threshold
//   wr_level        registered fill level
//   overflow        sticky write-while-full flag
interface fifo_wptr_full_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rptr_gray_async;
  logic                  ovf_clr;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  modport master (
    output wr_en, rptr_gray_async, ovf_clr,
    input  wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, rptr_gray_async, ovf_clr,
    output wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-clock-domain pointer and flag generator for the async FIFO.
// Keeps the binary write pointer, publishes a registered Gray pointer, resynchronises
// the read-side Gray pointer and derives full / almost_full / level / sticky overflow.
// Ports:
//   clk    write-domain clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_wptr_full_if.slave (see interface file for signal list)
// ADDR_WIDTH must be >= 2 so the full comparison has distinct top two bits.
module fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = 12,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic            clk,
  input logic            rst_n,
  fifo_wptr_full_if.slave bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits
  // inverted (one lap ahead).
  localparam logic [PW-1:0] FullMask = {2'b11, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] AfThresh = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gnext;
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wptr_gray_q;
  logic [PW-1:0] wr_level_q;
  logic          full_q;
  logic          almost_full_q;
  logic          overflow_q;
  logic          overflow_d;
  logic          wr_accept;

  assign wr_accept  = bus.wr_en & ~full_q;
  assign wbin_next  = wbin_q + PW'(wr_accept);
  assign gnext      = wbin_next ^ (wbin_next >> 1);
  assign rq         = sync_q[SYNC_STAGES-1];
  assign level_next = wbin_next - rbin;

  // Gray to binary: each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  // A new overflowing write wins over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      wbin_q        <= '0;
      wptr_gray_q   <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q[0] <= bus.rptr_gray_async;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      wbin_q        <= wbin_next;
      wptr_gray_q   <= gnext;
      full_q        <= (gnext == (rq ^ FullMask));
      almost_full_q <= (level_next >= AfThresh);
      wr_level_q    <= level_next;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wr_accept   = wr_accept;
  assign bus.waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray   = wptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, AFULL_THRESH=12, SYNC_STAGES=2).
// Each step drives inputs, computes the expected registered outputs from a counter-based
// model, pushes them to a scoreboard queue and pops/compares them after the clock edge.
module tb_fifo_wptr_full;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(12),
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Model state
  logic [4:0] m_wbin;
  logic [4:0] m_s1;
  logic [4:0] m_s2;
  logic [4:0] m_rd;
  logic       m_full;
  logic       m_ovf;
  int         accepted;
  logic       wrap_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse Gray by search, independent of any XOR-chain formulation.
  function automatic logic [4:0] g2b(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (b2g(5'(b)) == g) return 5'(b);
    end
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_wbin = '0;
    m_s1   = '0;
    m_s2   = '0;
    m_rd   = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic step(input logic we, input logic [4:0] rp, input logic clr);
    exp_t       e;
    exp_t       got;
    logic       acc;
    logic [4:0] nb;
    logic [4:0] lvl;
    logic [4:0] prev_g;
    bus.wr_en           = we;
    bus.rptr_gray_async = rp;
    bus.ovf_clr         = clr;
    #1;
    acc = we & ~m_full;
    check_eq("wr_accept", 32'(bus.wr_accept), 32'(acc));
    prev_g = bus.wptr_gray;
    nb  = m_wbin + 5'(acc);
    lvl = nb - g2b(m_s2);
    if (m_wbin == 5'd31 && acc) wrap_seen = 1'b1;
    m_ovf  = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_full = (lvl == 5'd16);
    e.waddr = nb[3:0];
    e.gray  = b2g(nb);
    e.full  = m_full;
    e.af    = (lvl >= 5'd12);
    e.lvl   = lvl;
    e.ovf   = m_ovf;
    m_s2   = m_s1;
    m_s1   = rp;
    m_wbin = nb;
    if (acc) accepted++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("waddr", 32'(bus.waddr), 32'(got.waddr));
    check_eq("wptr_gray", 32'(bus.wptr_gray), 32'(got.gray));
    check_eq("full", 32'(bus.full), 32'(got.full));
    check_eq("almost_full", 32'(bus.almost_full), 32'(got.af));
    check_eq("wr_level", 32'(bus.wr_level), 32'(got.lvl));
    check_eq("overflow", 32'(bus.overflow), 32'(got.ovf));
    check_eq("gray_hamming", $countones(bus.wptr_gray ^ prev_g), 32'(acc));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_waddr"}, 32'(bus.waddr), 0);
    check_eq({tag, "_gray"}, 32'(bus.wptr_gray), 0);
    check_eq({tag, "_full"}, 32'(bus.full), 0);
    check_eq({tag, "_af"}, 32'(bus.almost_full), 0);
    check_eq({tag, "_level"}, 32'(bus.wr_level), 0);
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 0);
  endtask

  initial begin
    int start;
    rst_n               = 1'b0;
    bus.wr_en           = 1'b0;
    bus.rptr_gray_async = '0;
    bus.ovf_clr         = 1'b0;
    accepted            = 0;
    wrap_seen           = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");
    check_eq("reset_wr_accept", 32'(bus.wr_accept), 0);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);

    // Fill: 16 writes with read pointer at 0.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'd0, 1'b0);
      check_eq("af_rise", 32'(bus.almost_full), 32'(i >= 12));
      check_eq("full_on_16", 32'(bus.full), 32'(i == 16));
    end
    check_eq("full_gray", 32'(bus.wptr_gray), 32'(5'b11000));
    check_eq("full_level", 32'(bus.wr_level), 16);

    // Writes while full: rejected, overflow sticky; then clear, then set-wins.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd0, 1'b0);
      check_eq("ovf_set", 32'(bus.overflow), 1);
      check_eq("ovf_waddr_hold", 32'(bus.waddr), 0);
    end
    step(1'b0, 5'd0, 1'b1);
    check_eq("ovf_clr", 32'(bus.overflow), 0);
    step(1'b1, 5'd0, 1'b1);
    check_eq("ovf_set_wins", 32'(bus.overflow), 1);
    step(1'b0, 5'd0, 1'b1);

    // Read frees one slot: visible exactly three edges later.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'b00001, 1'b0);
      check_eq("free_full", 32'(bus.full), 32'(k < 2));
      check_eq("free_level", 32'(bus.wr_level), (k < 2) ? 16 : 15);
    end

    // 40 accepted writes interleaved with random read advances.
    m_rd  = 5'd1;
    start = accepted;
    for (int cyc = 0; cyc < 400 && (accepted - start) < 40; cyc++) begin
      logic we_r;
      we_r = ($urandom_range(0, 3) != 0);
      if ((m_wbin - m_rd) != 5'd0 && $urandom_range(0, 1) == 1) m_rd = m_rd + 5'd1;
      step(we_r, b2g(m_rd), 1'b0);
    end
    check_eq("forty_writes", 32'((accepted - start) >= 40), 1);
    check_eq("ptr_wrapped", 32'(wrap_seen), 1);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, b2g(m_rd), 1'b0);
    step(1'b1, b2g(m_rd), 1'b0);
    bus.wr_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    bus.wr_en           = 1'b0;
    bus.rptr_gray_async = '0;
    #4;
    rst_n = 1'b1;
    check_eq("rst_waddr", 32'(bus.waddr), 0);
    step(1'b1, 5'd0, 1'b0);
    check_eq("first_write_after_rst", 32'(bus.waddr), 1);
    step(1'b1, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
